// File: rtl/if_instr_fifo.sv
// if_instr_fifo: instruction fetch buffer between the I-cache response path
// and the IF/ID pipeline register. Entries are {instr, PC, exception bundle}
// held in a DEPTH-entry circular buffer; the head entry is presented
// combinationally and popped whenever ID_Reg loads it (ID_Wr with IF_Valid).
// Optional feature macro: IF_FIFO_BYPASS_EN -- when the buffer is empty the
// incoming fetch word is shown on the head outputs in the same cycle, and is
// consumed directly (never written) if ID_Wr is high in that cycle.
module if_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int EXC_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     IF_Flush,
   input  logic                     ID_Wr,
   input  logic                     Fetch_Valid,
   output logic                     Fetch_Ready,
   input  logic [31:0]              Fetch_Instr,
   input  logic [31:0]              Fetch_PC,
   input  logic [EXC_W-1:0]         Fetch_ExceptType,
   output logic                     IF_Valid,
   output logic [31:0]              IF_Instr,
   output logic [31:0]              IF_PC,
   output logic [EXC_W-1:0]         IF_ExceptType,
   output logic [$clog2(DEPTH):0]   IF_Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]       instr_mem_r [DEPTH];
   logic [31:0]       pc_mem_r    [DEPTH];
   logic [EXC_W-1:0]  exc_mem_r   [DEPTH];

   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  count_r;

   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              bypass_s;
   logic              wr_en_s;
   logic              rd_en_s;

   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign full_s  = (count_r == FULL_CNT);

   // Ready depends on registered occupancy only; it never anticipates a pop.
   assign Fetch_Ready = !full_s;
   assign push_s      = Fetch_Valid && !full_s;

`ifdef IF_FIFO_BYPASS_EN
   // Empty buffer forwards the live fetch word unless a flush/reset is active.
   assign bypass_s = empty_s && Fetch_Valid && !IF_Flush && !rst;
`else
   assign bypass_s = 1'b0;
`endif

   // A bypassed word taken by ID in the same cycle never enters storage.
   assign wr_en_s = push_s && !(bypass_s && ID_Wr);
   // Pops only come from stored entries; an empty pop is a bubble.
   assign rd_en_s = ID_Wr && !empty_s;

   // Entry storage: written at wr_ptr, never cleared (pointers define validity).
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         instr_mem_r[wr_ptr_r] <= Fetch_Instr;
         pc_mem_r[wr_ptr_r]    <= Fetch_PC;
         exc_mem_r[wr_ptr_r]   <= Fetch_ExceptType;
      end
   end

   // Pointer and occupancy state with reset over flush over push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (IF_Flush) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
      end
   end

   // Head outputs: stored head, else bypassed fetch word, else an all-zero NOP.
   always_comb begin
      IF_Valid      = 1'b0;
      IF_Instr      = 32'h0000_0000;
      IF_PC         = 32'h0000_0000;
      IF_ExceptType = {EXC_W{1'b0}};
      if (!empty_s) begin
         IF_Valid      = 1'b1;
         IF_Instr      = instr_mem_r[rd_ptr_r];
         IF_PC         = pc_mem_r[rd_ptr_r];
         IF_ExceptType = exc_mem_r[rd_ptr_r];
      end else if (bypass_s) begin
         IF_Valid      = 1'b1;
         IF_Instr      = Fetch_Instr;
         IF_PC         = Fetch_PC;
         IF_ExceptType = Fetch_ExceptType;
      end else begin
         IF_Valid      = 1'b0;
         IF_Instr      = 32'h0000_0000;
         IF_PC         = 32'h0000_0000;
         IF_ExceptType = {EXC_W{1'b0}};
      end
   end

   assign IF_Count = count_r;

endmodule

// File: tb/tb_if_instr_fifo.sv
// Testbench for if_instr_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_if_instr_fifo;

   localparam int DEPTH = 4;
   localparam int EXC_W = 32;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IF_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, IF_Flush, ID_Wr, Fetch_Valid, Fetch_Ready;
   logic [31:0]       Fetch_Instr, Fetch_PC, IF_Instr, IF_PC;
   logic [EXC_W-1:0]  Fetch_ExceptType, IF_ExceptType;
   logic              IF_Valid;
   logic [CW-1:0]     IF_Count;

   always #5 clk = ~clk;

   if_instr_fifo #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
      .clk(clk), .rst(rst), .IF_Flush(IF_Flush), .ID_Wr(ID_Wr),
      .Fetch_Valid(Fetch_Valid), .Fetch_Ready(Fetch_Ready),
      .Fetch_Instr(Fetch_Instr), .Fetch_PC(Fetch_PC),
      .Fetch_ExceptType(Fetch_ExceptType), .IF_Valid(IF_Valid),
      .IF_Instr(IF_Instr), .IF_PC(IF_PC), .IF_ExceptType(IF_ExceptType),
      .IF_Count(IF_Count)
   );

   typedef struct {
      logic [31:0]      instr;
      logic [31:0]      pc;
      logic [EXC_W-1:0] exc;
   } ent_t;

   typedef struct {
      logic        rst, flush, idwr, fv;
      logic [31:0] pc;
      logic        ev, er;
      logic [CW-1:0] ec;
      logic [31:0] epc;
   } vec_t;

   ent_t   q[$];
   vec_t   tbl[15];
   int     n_chk  = 0;
   int     n_pass = 0;
   bit     byp_now;
   bit     saw_flushed;
   logic [31:0] popped[$];

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic f, input logic w, input logic v,
                        input logic [31:0] pc, input logic [EXC_W-1:0] exc);
      rst = r; IF_Flush = f; ID_Wr = w; Fetch_Valid = v;
      Fetch_PC = pc; Fetch_Instr = mk_instr(pc); Fetch_ExceptType = exc;
   endtask

   // Compare every output with the model, clock one edge, then update the model.
   task automatic step();
      ent_t e, fe;
      bit   ev;
      #3;
      fe.instr = Fetch_Instr; fe.pc = Fetch_PC; fe.exc = Fetch_ExceptType;
      byp_now = BYP && (q.size() == 0) && Fetch_Valid && !IF_Flush && !rst;
      ev = (q.size() > 0) || byp_now;
      if (q.size() > 0) e = q[0];
      else if (byp_now) e = fe;
      else begin e.instr = 32'h0; e.pc = 32'h0; e.exc = '0; end
      chk("valid", IF_Valid, ev);
      chk("ready", Fetch_Ready, q.size() < DEPTH);
      chk("count", IF_Count, q.size());
      chk("instr", IF_Instr, e.instr);
      chk("pc", IF_PC, e.pc);
      chk("exc", IF_ExceptType, e.exc);
      if (IF_Valid && IF_PC == 32'h8000_0100) saw_flushed = 1'b1;
      if (IF_Valid && ID_Wr) popped.push_back(IF_PC);
      @(posedge clk);
      if (rst || IF_Flush) q.delete();
      else if (!(byp_now && ID_Wr)) begin
         bit pop_m, push_m;
         pop_m  = ID_Wr && (q.size() > 0);
         push_m = Fetch_Valid && (q.size() < DEPTH);
         if (pop_m) void'(q.pop_front());
         if (push_m) q.push_back(fe);
      end
      #1;
   endtask

   function automatic vec_t mkv(input logic r, input logic f, input logic w, input logic v,
                                input logic [31:0] pc, input logic ev, input logic er,
                                input int ec, input logic [31:0] epc);
      vec_t t;
      t.rst = r; t.flush = f; t.idwr = w; t.fv = v; t.pc = pc;
      t.ev = ev; t.er = er; t.ec = CW'(ec); t.epc = epc;
      return t;
   endfunction

   initial begin
      // Fill/drain then mid-stream reset; expectations are pre-edge outputs.
      tbl[0]  = mkv(0,0,0,1,32'hBFC0_0000, BYP,1,0, BYP ? 32'hBFC0_0000 : 32'h0);
      tbl[1]  = mkv(0,0,0,1,32'hBFC0_0004, 1,1,1, 32'hBFC0_0000);
      tbl[2]  = mkv(0,0,0,1,32'hBFC0_0008, 1,1,2, 32'hBFC0_0000);
      tbl[3]  = mkv(0,0,0,1,32'hBFC0_000C, 1,1,3, 32'hBFC0_0000);
      tbl[4]  = mkv(0,0,0,1,32'hBFC0_0010, 1,0,4, 32'hBFC0_0000);
      tbl[5]  = mkv(0,0,1,0,32'h0,         1,0,4, 32'hBFC0_0000);
      tbl[6]  = mkv(0,0,1,0,32'h0,         1,1,3, 32'hBFC0_0004);
      tbl[7]  = mkv(0,0,1,0,32'h0,         1,1,2, 32'hBFC0_0008);
      tbl[8]  = mkv(0,0,1,0,32'h0,         1,1,1, 32'hBFC0_000C);
      tbl[9]  = mkv(0,0,1,0,32'h0,         0,1,0, 32'h0);
      tbl[10] = mkv(0,0,0,1,32'h0000_00A0, BYP,1,0, BYP ? 32'h0000_00A0 : 32'h0);
      tbl[11] = mkv(0,0,0,1,32'h0000_00A4, 1,1,1, 32'h0000_00A0);
      tbl[12] = mkv(0,0,0,1,32'h0000_00A8, 1,1,2, 32'h0000_00A0);
      tbl[13] = mkv(1,0,0,1,32'h0000_00AC, 1,1,3, 32'h0000_00A0);
      tbl[14] = mkv(0,0,0,0,32'h0,         0,1,0, 32'h0);

      saw_flushed = 1'b0;
      drive(1,0,0,0,32'h0,'0);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rst, tbl[i].flush, tbl[i].idwr, tbl[i].fv, tbl[i].pc, '0);
         #3;
         chk($sformatf("tbl%0d_valid", i), IF_Valid, tbl[i].ev);
         chk($sformatf("tbl%0d_ready", i), Fetch_Ready, tbl[i].er);
         chk($sformatf("tbl%0d_count", i), IF_Count, tbl[i].ec);
         chk($sformatf("tbl%0d_pc", i), IF_PC, tbl[i].epc);
         chk($sformatf("tbl%0d_instr", i), IF_Instr, tbl[i].ev ? mk_instr(tbl[i].epc) : 32'h0);
         chk($sformatf("tbl%0d_exc", i), IF_ExceptType, 32'h0);
         @(posedge clk);
         #1;
      end
      q.delete();

      // Flush with a simultaneous push: the flushed-cycle word never appears.
      for (int i = 0; i < 3; i++) begin drive(0,0,0,1,32'h8000_0000 + 32'(4*i),'0); step(); end
      drive(0,1,0,1,32'h8000_0100,'0); step();
      drive(0,0,0,0,32'h0,'0); step();
      chk("flush_count", IF_Count, 0);
      chk("flush_valid", IF_Valid, 1'b0);
      repeat (3) step();
      chk("flush_never_out", saw_flushed, 1'b0);

      // Exception entry followed by a clean entry.
      drive(0,0,0,1,32'h0000_0200,32'h1); step();
      drive(0,0,0,1,32'h0000_0204,'0); step();
      drive(0,0,0,0,32'h0,'0); #3;
      chk("exc_head", IF_ExceptType, 32'h1);
      step();
      drive(0,0,1,0,32'h0,'0); step();
      drive(0,0,0,0,32'h0,'0); #3;
      chk("exc_next", IF_ExceptType, 32'h0);
      chk("exc_next_pc", IF_PC, 32'h0000_0204);
      step();
      drive(0,0,1,0,32'h0,'0); step();

      // Empty pop, with the same-cycle bypass variant where enabled.
      drive(0,0,1,0,32'h0,'0); step();
      drive(0,0,1,BYP,32'h0,'0);
      Fetch_Instr = 32'h2402_0001;
      #3;
      chk("empty_pop_instr", IF_Instr, BYP ? 32'h2402_0001 : 32'h0);
      chk("empty_pop_exc", IF_ExceptType, 32'h0);
      @(posedge clk); #1;
      chk("empty_pop_count", IF_Count, 0);

      // Wrap-around: steady push+pop at count 2 keeps order and occupancy.
      popped.delete();
      drive(0,0,0,1,32'h0000_00C0,'0); step();
      drive(0,0,0,1,32'h0000_00C4,'0); step();
      for (int i = 0; i < 10; i++) begin
         drive(0,0,1,1,32'h0000_00C8 + 32'(4*i),'0); step();
         chk("wrap_count", IF_Count, 2);
      end
      chk("wrap_npop", popped.size(), 10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         chk($sformatf("wrap_pc%0d", i), popped[i], 32'h0000_00C0 + 32'(4*i));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         drive(r < 2, (r >= 2) && (r < 5), 1'($urandom_range(0,1)),
               $urandom_range(0,9) < 6, $urandom & 32'hFFFF_FFFC,
               ($urandom_range(0,7) == 0) ? EXC_W'($urandom) : '0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/if_instr_fifo.md
Name: if_instr_fifo

Overview:
- Instruction fetch buffer between the I-cache response path and the IF/ID pipeline register.
- Queues fetched {instr, PC, exception} entries and presents the head entry on IF_Instr/IF_PC/IF_ExceptType.
- ID_Reg samples the head when ID_Wr is high; each such sample pops one entry.
- Decouples fetch bursts from ID stalls; flushed with the front end on redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- EXC_W, 32, width of the flattened per-entry exception bundle (matches the packed ExceptinPipeType).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous reset, active-high (`RstEnable = 1).
- IF_Flush  input  1  clear all entries (branch/exception redirect).
- ID_Wr  input  1  ID_Reg load enable; pops head when IF_Valid=1.
- Fetch_Valid  input  1  fetch response valid.
- Fetch_Ready  output  1  space available; equals !full.
- Fetch_Instr  input  32  fetched instruction word.
- Fetch_PC  input  32  PC of the fetched word.
- Fetch_ExceptType  input  EXC_W  exceptions detected at fetch (TLB, address error).
- IF_Valid  output  1  head entry present.
- IF_Instr  output  32  head instruction; 32'b0 (NOP) when empty.
- IF_PC  output  32  head PC; 32'b0 when empty.
- IF_ExceptType  output  EXC_W  head exception bundle; '0 when empty.
- IF_Count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer; rd_ptr, wr_ptr of $clog2(DEPTH) bits; separate count register.
- Pointer arithmetic: pointers wrap modulo DEPTH; full is count==DEPTH, empty is count==0.
- Reset (rst=1, synchronous): rd_ptr=0, wr_ptr=0, count=0.
  - Reset therefore forces IF_Valid=0, Fetch_Ready=1, IF_Count=0, and IF_Instr/IF_PC/IF_ExceptType=0.
  - Reset overrides every other input, including mid-burst.
- Push: when Fetch_Valid && Fetch_Ready, write {Fetch_Instr, Fetch_PC, Fetch_ExceptType} at wr_ptr, then wr_ptr++.
  - Fetch_Valid while full is ignored; the producer must hold the data until Fetch_Ready=1.
- Pop: when ID_Wr && IF_Valid, rd_ptr++.
  - ID_Wr while empty pops nothing; ID_Reg latches the zero outputs as a bubble.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, Fetch_Ready stays 0 that cycle: ready is registered-state based and does not look ahead to the pop.
- Count update: count_next = count + push - pop.
- Outputs: head outputs are driven combinationally from the entry at rd_ptr, gated to zero when empty.
  - Latency: a pushed entry first appears on the outputs the cycle after the push.
- Flush (IF_Flush=1, rst=0): same-cycle effect equals reset.
  - Any push or pop in that cycle is discarded.
  - Entry contents need not be cleared.
- Flush/reset and ID_Reg on the same edge: ID_Reg is also flushed by its own flush input, so no valid entry leaks into ID.
- Priority: rst > IF_Flush > push/pop.
- Exception entries: queued and popped like any other entry; there is no special stall.

Optional Feature:
- IF_FIFO_BYPASS_EN defined: when empty, Fetch_Valid=1 and IF_Flush=0, the head outputs show the Fetch_* inputs in the same cycle and IF_Valid=1.
  - If ID_Wr=1 in that cycle, the entry is consumed directly and is not written.
  - If ID_Wr=0, the entry is written normally.
  - Flush and reset still force IF_Valid=0.
- IF_FIFO_BYPASS_EN undefined: no bypass; minimum latency is one cycle as described above.

Test Plan:
- Reset: assert rst mid-stream with count=3 -> next cycle IF_Valid=0, IF_Count=0, Fetch_Ready=1, IF_Instr=0, IF_PC=0.
- Fill and drain: push PCs 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C with ID_Wr=0.
  - After the 4th push: Fetch_Ready=0 and IF_Count=4.
  - A 5th push of 0xBFC00010 is held off.
  - Then ID_Wr=1 for 4 cycles -> IF_PC sequence 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C, then IF_Valid=0.
- Wrap-around: 10 back-to-back push+pop cycles at count=2 -> count stays 2; PCs exit in order across pointer wrap; no duplicates or drops.
- Flush with push: count=3, IF_Flush=1, Fetch_Valid=1 with PC 0x80000100 in the same cycle -> next cycle IF_Count=0, IF_Valid=0; 0x80000100 is never output.
- Empty pop: count=0, ID_Wr=1 -> IF_Instr=0, IF_ExceptType=0; count stays 0 and no pointer underflow.
  - With bypass enabled, add Fetch_Valid=1 with Instr 0x24020001 -> IF_Instr=0x24020001 in the same cycle and IF_Count stays 0.
- Exception entry: push with Fetch_ExceptType bit 0 set -> IF_ExceptType shows that bit 0 when the entry reaches the head; the following entry shows IF_ExceptType='0.
